fetch_unit: RTL and testbench

- Program-counter and instruction-register stage of the 16-bit RISC CPU; it sits directly upstream of the control unit.
- Holds PC and IR and drives the memory address mux (PC or register operand).
- Computes branch and jump targets, and stalls the control unit through a ready/wait handshake while instruction memory is not ready.
- Also keeps a saturating retired-instruction counter for debug LEDs and benches.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_unit_if.sv | 46 ++++
 rtl/pc_trace_buf.sv | 38 +++
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, fetch FSM encoding and sign-extension helper.
package cpu_pkg;

    localparam int WORD_W = 16;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

    function automatic logic [WORD_W-1:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Control/memory bundle between the control unit and fetch_unit.
// FETCH_TRACE_EN adds the branch-trace read port.
interface fetch_unit_if #(
    parameter int CNT_W = 16
);
    import cpu_pkg::*;

    logic              pc_ld;
    logic              pc_inc;
    logic              pc_sel;
    logic              ir_ld;
    logic              adr_sel;
    logic [WORD_W-1:0] r_data;
    logic [WORD_W-1:0] s_data;
    logic [WORD_W-1:0] mem_din;
    logic              mem_ready;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] ir;
    logic              fetch_wait;
    logic [CNT_W-1:0]  retired;
`ifdef FETCH_TRACE_EN
    logic [2:0]        trace_idx;
    logic [WORD_W-1:0] trace_pc;
    logic [7:0]        trace_valid;

    modport master (
        output pc_ld, pc_inc, pc_sel, ir_ld, adr_sel, r_data, s_data, mem_din, mem_ready, trace_idx,
        input  mem_addr, pc, ir, fetch_wait, retired, trace_pc, trace_valid
    );
    modport slave (
        input  pc_ld, pc_inc, pc_sel, ir_ld, adr_sel, r_data, s_data, mem_din, mem_ready, trace_idx,
        output mem_addr, pc, ir, fetch_wait, retired, trace_pc, trace_valid
    );
`else
    modport master (
        output pc_ld, pc_inc, pc_sel, ir_ld, adr_sel, r_data, s_data, mem_din, mem_ready,
        input  mem_addr, pc, ir, fetch_wait, retired
    );
    modport slave (
        input  pc_ld, pc_inc, pc_sel, ir_ld, adr_sel, r_data, s_data, mem_din, mem_ready,
        output mem_addr, pc, ir, fetch_wait, retired
    );
`endif

endinterface

// File: rtl/pc_trace_buf.sv
// 8-entry circular log of the PC seen at each taken PC load (FETCH_TRACE_EN only).
module pc_trace_buf
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [WORD_W-1:0] wr_pc,
    input  logic [2:0]        rd_idx,
    output logic [WORD_W-1:0] rd_pc,
    output logic [7:0]        valid
);

    logic [WORD_W-1:0] mem_q [8];
    logic [2:0]        ptr_q;
    logic [7:0]        valid_q;

    // Entry storage needs no reset; the valid mask says which entries mean anything.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[ptr_q] <= wr_pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q   <= 3'd0;
            valid_q <= 8'h00;
        end else if (wr_en) begin
            ptr_q          <= ptr_q + 3'd1;
            valid_q[ptr_q] <= 1'b1;
        end
    end

    assign rd_pc = mem_q[rd_idx];
    assign valid = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// PC/IR stage with memory-ready stall handshake and saturating retire counter.
// Optional branch trace buffer enabled by FETCH_TRACE_EN.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
    parameter int                CNT_W    = 16
) (
    input  logic        clk,
    input  logic        reset,
    fetch_unit_if.slave bus
);

    fetch_state_e      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    logic [WORD_W-1:0] pc_fetch_q, pc_fetch_d;
    logic              pend_inc_q, pend_inc_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic [CNT_W-1:0]  retired_sat;
    logic              fetch_wait;

    assign retired_sat = (&retired_q) ? retired_q : retired_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            ir_q       <= '0;
            pc_fetch_q <= RESET_PC;
            pend_inc_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            pc_fetch_q <= pc_fetch_d;
            pend_inc_q <= pend_inc_d;
            retired_q  <= retired_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        pc_fetch_d   = pc_fetch_q;
        pend_inc_d   = pend_inc_q;
        retired_d    = retired_q;
        fetch_wait   = 1'b0;
        bus.mem_addr = bus.adr_sel ? bus.r_data : pc_q;
        case (state_q)
            RUN: begin
                if (bus.ir_ld) begin
                    // A simultaneous pc_ld is illegal and deliberately dropped here.
                    if (bus.mem_ready) begin
                        ir_d      = bus.mem_din;
                        retired_d = retired_sat;
                        if (bus.pc_inc) pc_d = pc_q + 16'd1;
                    end else begin
                        fetch_wait = 1'b1;
                        state_d    = WAIT;
                        pc_fetch_d = pc_q;
                        pend_inc_d = bus.pc_inc;
                    end
                end else if (bus.pc_ld) begin
                    pc_d = bus.pc_sel ? bus.s_data : pc_q + sext8(ir_q[7:0]);
                end else if (bus.pc_inc) begin
                    pc_d = pc_q + 16'd1;
                end
            end
            WAIT: begin
                bus.mem_addr = pc_fetch_q;
                if (bus.mem_ready) begin
                    ir_d      = bus.mem_din;
                    pc_d      = pc_q + {{(WORD_W-1){1'b0}}, pend_inc_q};
                    retired_d = retired_sat;
                    state_d   = RUN;
                end else begin
                    fetch_wait = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Keep the stall request low while reset is held, whatever the inputs do.
    assign bus.fetch_wait = fetch_wait & reset;
    assign bus.pc         = pc_q;
    assign bus.ir         = ir_q;
    assign bus.retired    = retired_q;

`ifdef FETCH_TRACE_EN
    logic pc_taken;
    assign pc_taken = (state_q == RUN) & ~bus.ir_ld & bus.pc_ld;

    pc_trace_buf u_trace (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (pc_taken),
        .wr_pc  (pc_q),
        .rd_idx (bus.trace_idx),
        .rd_pc  (bus.trace_pc),
        .valid  (bus.trace_valid)
    );
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; retire counter narrowed to 4 bits to reach saturation quickly.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fetch_unit_if #(.CNT_W(4)) bus ();

    fetch_unit #(
        .RESET_PC (16'h0000),
        .CNT_W    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.pc_ld     = 1'b0;
        bus.pc_inc    = 1'b0;
        bus.pc_sel    = 1'b0;
        bus.ir_ld     = 1'b0;
        bus.adr_sel   = 1'b0;
        bus.r_data    = 16'h0000;
        bus.s_data    = 16'h0000;
        bus.mem_din   = 16'h0000;
        bus.mem_ready = 1'b0;
`ifdef FETCH_TRACE_EN
        bus.trace_idx = 3'd0;
`endif
    endtask

    task automatic fetch(input logic [15:0] din, input logic inc);
        idle();
        bus.ir_ld     = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_din   = din;
        bus.pc_inc    = inc;
        tick();
        idle();
    endtask

    task automatic jump(input logic [15:0] target);
        idle();
        bus.pc_ld  = 1'b1;
        bus.pc_sel = 1'b1;
        bus.s_data = target;
        tick();
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.pc_ld     = 1'($urandom);
            bus.pc_inc    = 1'($urandom);
            bus.pc_sel    = 1'($urandom);
            bus.ir_ld     = 1'b1;
            bus.adr_sel   = 1'b0;
            bus.mem_ready = 1'b0;
            bus.mem_din   = 16'($urandom);
            bus.s_data    = 16'($urandom);
            tick();
        end
        chk("rst_pc", bus.pc, 16'h0000);
        chk("rst_ir", bus.ir, 16'h0000);
        chk("rst_retired", {12'h000, bus.retired}, 16'h0000);
        chk("rst_fetch_wait", {15'h0, bus.fetch_wait}, 16'h0000);

        idle();
        reset = 1'b1;
        tick();
        tick();
        chk("post_rst_pc", bus.pc, 16'h0000);
        chk("post_rst_ir", bus.ir, 16'h0000);

        for (int i = 0; i < 5; i++) begin
            bus.pc_inc = 1'b1;
            tick();
        end
        idle();
        chk("inc_pc", bus.pc, 16'h0005);

        fetch(16'hE0C2, 1'b1);
        chk("zw_ir", bus.ir, 16'hE0C2);
        chk("zw_pc", bus.pc, 16'h0006);
        chk("zw_retired", {12'h000, bus.retired}, 16'h0001);

        // Two stall cycles; control inputs wander during WAIT and must be ignored.
        bus.ir_ld  = 1'b1;
        bus.pc_inc = 1'b1;
        #1;
        chk("ws_wait_c1", {15'h0, bus.fetch_wait}, 16'h0001);
        chk("ws_addr_c1", bus.mem_addr, 16'h0006);
        tick();
        idle();
        bus.adr_sel = 1'b1;
        bus.r_data  = 16'h00A0;
        bus.pc_ld   = 1'b1;
        bus.pc_sel  = 1'b1;
        bus.s_data  = 16'h4321;
        #1;
        chk("ws_wait_c2", {15'h0, bus.fetch_wait}, 16'h0001);
        chk("ws_addr_c2", bus.mem_addr, 16'h0006);
        tick();
        bus.mem_ready = 1'b1;
        bus.mem_din   = 16'hF201;
        #1;
        chk("ws_wait_c3", {15'h0, bus.fetch_wait}, 16'h0000);
        chk("ws_addr_c3", bus.mem_addr, 16'h0006);
        tick();
        idle();
        chk("ws_ir", bus.ir, 16'hF201);
        chk("ws_pc", bus.pc, 16'h0007);
        chk("ws_retired", {12'h000, bus.retired}, 16'h0002);
        chk("ws_wait_done", {15'h0, bus.fetch_wait}, 16'h0000);

        fetch(16'h00FE, 1'b0);
        jump(16'h0010);
        chk("jmp_pc", bus.pc, 16'h0010);
        bus.pc_ld = 1'b1;
        tick();
        idle();
        chk("br_back", bus.pc, 16'h000E);

        jump(16'hFFFD);
        fetch(16'h0005, 1'b0);
        bus.pc_ld = 1'b1;
        tick();
        idle();
        chk("br_wrap", bus.pc, 16'h0002);

        bus.pc_ld  = 1'b1;
        bus.pc_inc = 1'b1;
        bus.pc_sel = 1'b1;
        bus.s_data = 16'h1234;
        tick();
        idle();
        chk("ld_over_inc", bus.pc, 16'h1234);

        bus.adr_sel = 1'b1;
        bus.r_data  = 16'h00A0;
        #1;
        chk("mux_r", bus.mem_addr, 16'h00A0);
        bus.adr_sel = 1'b0;
        #1;
        chk("mux_pc", bus.mem_addr, 16'h1234);

        bus.ir_ld     = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_din   = 16'h0003;
        bus.pc_ld     = 1'b1;
        bus.pc_sel    = 1'b1;
        bus.s_data    = 16'hBEEF;
        tick();
        idle();
        chk("irld_pcld_pc", bus.pc, 16'h1234);
        chk("irld_pcld_ir", bus.ir, 16'h0003);

        jump(16'hFFFF);
        bus.pc_inc = 1'b1;
        tick();
        idle();
        chk("inc_wrap", bus.pc, 16'h0000);

        chk("sat_pre", {12'h000, bus.retired}, 16'h0005);
        for (int i = 0; i < 10; i++) fetch(16'h1000 + 16'(i), 1'b0);
        chk("sat_full", {12'h000, bus.retired}, 16'h000F);
        fetch(16'h2222, 1'b0);
        chk("sat_hold", {12'h000, bus.retired}, 16'h000F);

        // Reset during WAIT must abandon the pending fetch.
        jump(16'h0040);
        bus.ir_ld = 1'b1;
        tick();
        idle();
        bus.mem_ready = 1'b1;
        bus.mem_din   = 16'hAAAA;
        reset = 1'b0;
        #1;
        chk("rw_ir", bus.ir, 16'h0000);
        chk("rw_pc", bus.pc, 16'h0000);
        chk("rw_wait", {15'h0, bus.fetch_wait}, 16'h0000);
        tick();
        reset = 1'b1;
        idle();
        tick();
        chk("rw_ir_after", bus.ir, 16'h0000);
        chk("rw_retired", {12'h000, bus.retired}, 16'h0000);

`ifdef FETCH_TRACE_EN
        chk("tr_empty", {8'h00, bus.trace_valid}, 16'h0000);
        for (int k = 0; k < 9; k++) jump(16'h0100 * 16'(k + 1));
        chk("tr_valid", {8'h00, bus.trace_valid}, 16'h00FF);
        bus.trace_idx = 3'd0;
        #1;
        chk("tr_e0", bus.trace_pc, 16'h0800);
        bus.trace_idx = 3'd1;
        #1;
        chk("tr_e1", bus.trace_pc, 16'h0100);
        bus.trace_idx = 3'd7;
        #1;
        chk("tr_e7", bus.trace_pc, 16'h0700);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
